// File: rtl/dl_multi_if.sv
// Bus bundle for dl_multi: GPIO config word, ADC samples, trigger inputs and per-channel lock status.
interface dl_multi_if #(
    parameter int NUM_CH    = 4,
    parameter int NUM_LANES = 16
);
    logic [31:0]             gpio_in;
    logic [16*NUM_LANES-1:0] adc_data_in;
    logic                    lock_sig_active;
    logic [NUM_CH-1:0]       trig_lock;
    logic [NUM_CH-1:0]       lock_done;
    logic [NUM_CH-1:0]       locked;
    logic [NUM_CH-1:0]       lock_fail;
    logic [16*NUM_CH-1:0]    setpt_out_ext;

    modport master (
        output gpio_in, adc_data_in, lock_sig_active, trig_lock,
        input  lock_done, locked, lock_fail, setpt_out_ext
    );

    modport slave (
        input  gpio_in, adc_data_in, lock_sig_active, trig_lock,
        output lock_done, locked, lock_fail, setpt_out_ext
    );
endinterface

// File: rtl/dl_multi.sv
// Multi-channel dynamic lockbox: each channel averages one ADC lane and hill-climbs its
// 16-bit bias setpoint until the average sits within tolerance of the expected value.
module dl_multi #(
    parameter int NUM_CH    = 4,
    parameter int NUM_LANES = 16,
    parameter int BASE_ADDR = 0,
    parameter int MAX_ITER  = 1024
) (
    input logic       clk,
    input logic       rst,
    dl_multi_if.slave bus
);
    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int LANE_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
    localparam int ITER_W = $clog2(MAX_ITER) + 1;

    typedef enum logic [2:0] {
        ST_IDLE, ST_SETTLE, ST_ACCUM, ST_EVAL, ST_STEP, ST_LOCKED, ST_FAIL
    } state_t;

    logic [2:0]        strb_q, strb_d;
    logic              strb_rise, wr_en;
    logic [14:0]       gpio_addr, gpio_off;
    logic [15:0]       gpio_data;
    logic [CH_W-1:0]   wr_ch;
    logic [2:0]        wr_reg;

    logic [15:0]       setpt_max_q [NUM_CH], setpt_max_d [NUM_CH];
    logic [15:0]       setpt_init_q[NUM_CH], setpt_init_d[NUM_CH];
    logic [15:0]       exp_val_q   [NUM_CH], exp_val_d   [NUM_CH];
    logic [15:0]       tol_q       [NUM_CH], tol_d       [NUM_CH];
    logic [3:0]        avg_log2_q  [NUM_CH], avg_log2_d  [NUM_CH];
    logic [LANE_W-1:0] lane_sel_q  [NUM_CH], lane_sel_d  [NUM_CH];
    logic [15:0]       step_q      [NUM_CH], step_d      [NUM_CH];
    logic [15:0]       settle_q    [NUM_CH], settle_d    [NUM_CH];

    logic [15:0]       setpt_v [NUM_CH];
    logic              done_v  [NUM_CH];
    logic              locked_v[NUM_CH];
    logic              fail_v  [NUM_CH];

    // The strobe comes from a slow GPIO domain; addr/data are assumed stable around the edge.
    assign strb_d    = {strb_q[1:0], bus.gpio_in[31]};
    assign strb_rise = strb_q[1] & ~strb_q[2];
    assign gpio_addr = bus.gpio_in[30:16];
    assign gpio_data = bus.gpio_in[15:0];
    assign gpio_off  = gpio_addr - 15'(BASE_ADDR);
    assign wr_en     = strb_rise && (gpio_addr >= 15'(BASE_ADDR)) && (gpio_off < 15'(8*NUM_CH));
    assign wr_ch     = gpio_off[CH_W+2:3];
    assign wr_reg    = gpio_off[2:0];

    always_comb begin
        setpt_max_d  = setpt_max_q;
        setpt_init_d = setpt_init_q;
        exp_val_d    = exp_val_q;
        tol_d        = tol_q;
        avg_log2_d   = avg_log2_q;
        lane_sel_d   = lane_sel_q;
        step_d       = step_q;
        settle_d     = settle_q;
        if (wr_en) begin
            case (wr_reg)
                3'd0:    setpt_max_d[wr_ch]  = gpio_data;
                3'd1:    setpt_init_d[wr_ch] = gpio_data;
                3'd2:    exp_val_d[wr_ch]    = gpio_data;
                3'd3:    tol_d[wr_ch]        = gpio_data;
                3'd4:    avg_log2_d[wr_ch]   = (gpio_data > 16'd8) ? 4'd8 : gpio_data[3:0];
                3'd5:    lane_sel_d[wr_ch]   = LANE_W'(gpio_data % 16'(NUM_LANES));
                3'd6:    step_d[wr_ch]       = gpio_data;
                default: settle_d[wr_ch]     = gpio_data;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            strb_q <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                setpt_max_q[i]  <= '0;
                setpt_init_q[i] <= '0;
                exp_val_q[i]    <= '0;
                tol_q[i]        <= '0;
                avg_log2_q[i]   <= '0;
                lane_sel_q[i]   <= '0;
                step_q[i]       <= '0;
                settle_q[i]     <= '0;
            end
        end else begin
            strb_q       <= strb_d;
            setpt_max_q  <= setpt_max_d;
            setpt_init_q <= setpt_init_d;
            exp_val_q    <= exp_val_d;
            tol_q        <= tol_d;
            avg_log2_q   <= avg_log2_d;
            lane_sel_q   <= lane_sel_d;
            step_q       <= step_d;
            settle_q     <= settle_d;
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        state_t             state_q, state_d;
        logic [15:0]        setpt_q, setpt_d;
        logic               dir_q, dir_d;
        logic [ITER_W-1:0]  iter_q, iter_d;
        logic [16:0]        prev_err_q, prev_err_d;
        logic signed [23:0] acc_q, acc_d;
        logic [8:0]         cnt_q, cnt_d;
        logic [15:0]        settle_cnt_q, settle_cnt_d;
        logic [3:0]         avg_sh_q, avg_sh_d;
        logic               locked_q, locked_d, fail_q, fail_d, done_q, done_d;

        logic [15:0]        sample;
        logic signed [23:0] avg, err;
        logic [23:0]        aerr;
        logic [16:0]        sum_up;

        always_comb begin
            sample = '0;
            for (int k = 0; k < NUM_LANES; k++) begin
                if (lane_sel_q[c] == LANE_W'(k)) sample = bus.adc_data_in[16*k +: 16];
            end
        end

        assign avg    = acc_q >>> avg_sh_q;
        assign err    = avg - {{8{exp_val_q[c][15]}}, exp_val_q[c]};
        assign aerr   = err[23] ? 24'(-err) : 24'(err);
        assign sum_up = {1'b0, setpt_q} + {1'b0, step_q[c]};

        // Dropping trig_lock aborts from any state; the status flags survive until the next start.
        always_comb begin
            state_d      = state_q;
            setpt_d      = setpt_q;
            dir_d        = dir_q;
            iter_d       = iter_q;
            prev_err_d   = prev_err_q;
            acc_d        = acc_q;
            cnt_d        = cnt_q;
            settle_cnt_d = settle_cnt_q;
            avg_sh_d     = avg_sh_q;
            locked_d     = locked_q;
            fail_d       = fail_q;
            done_d       = done_q;
            if (!bus.trig_lock[c]) begin
                state_d = ST_IDLE;
                acc_d   = '0;
                cnt_d   = '0;
                done_d  = 1'b1;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        state_d      = ST_SETTLE;
                        setpt_d      = (setpt_init_q[c] < setpt_max_q[c]) ? setpt_init_q[c] : setpt_max_q[c];
                        dir_d        = 1'b1;
                        iter_d       = '0;
                        prev_err_d   = '1;
                        locked_d     = 1'b0;
                        fail_d       = 1'b0;
                        done_d       = 1'b0;
                        settle_cnt_d = '0;
                        acc_d        = '0;
                        cnt_d        = '0;
                    end
                    ST_SETTLE: begin
                        if (settle_cnt_q >= settle_q[c]) begin
                            state_d  = ST_ACCUM;
                            avg_sh_d = avg_log2_q[c];
                            acc_d    = '0;
                            cnt_d    = '0;
                        end else begin
                            settle_cnt_d = settle_cnt_q + 16'd1;
                        end
                    end
                    ST_ACCUM: begin
                        if (bus.lock_sig_active) begin
                            acc_d = acc_q + {{8{sample[15]}}, sample};
                            cnt_d = cnt_q + 9'd1;
                            if ((cnt_q + 9'd1) == (9'd1 << avg_sh_q)) state_d = ST_EVAL;
                        end
                    end
                    ST_EVAL: begin
                        prev_err_d = aerr[16:0];
                        acc_d      = '0;
                        cnt_d      = '0;
                        if (aerr <= {8'd0, tol_q[c]}) begin
                            state_d  = ST_LOCKED;
                            locked_d = 1'b1;
                            done_d   = 1'b1;
                        end else if (iter_q == ITER_W'(MAX_ITER - 1)) begin
                            state_d = ST_FAIL;
                            fail_d  = 1'b1;
                            done_d  = 1'b1;
                        end else begin
                            state_d = ST_STEP;
                            if (aerr > {7'd0, prev_err_q}) dir_d = ~dir_q;
                        end
                    end
                    ST_STEP: begin
                        state_d      = ST_SETTLE;
                        iter_d       = iter_q + 1'b1;
                        settle_cnt_d = '0;
                        if (dir_q) begin
                            if (sum_up > {1'b0, setpt_max_q[c]}) begin
                                setpt_d = setpt_max_q[c];
                                dir_d   = 1'b0;
                            end else begin
                                setpt_d = sum_up[15:0];
                            end
                        end else if (step_q[c] > setpt_q) begin
                            setpt_d = '0;
                            dir_d   = 1'b1;
                        end else begin
                            setpt_d = setpt_q - step_q[c];
                        end
                    end
                    default: ;
                endcase
            end
        end

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                state_q      <= ST_IDLE;
                setpt_q      <= '0;
                dir_q        <= 1'b1;
                iter_q       <= '0;
                prev_err_q   <= '1;
                acc_q        <= '0;
                cnt_q        <= '0;
                settle_cnt_q <= '0;
                avg_sh_q     <= '0;
                locked_q     <= 1'b0;
                fail_q       <= 1'b0;
                done_q       <= 1'b1;
            end else begin
                state_q      <= state_d;
                setpt_q      <= setpt_d;
                dir_q        <= dir_d;
                iter_q       <= iter_d;
                prev_err_q   <= prev_err_d;
                acc_q        <= acc_d;
                cnt_q        <= cnt_d;
                settle_cnt_q <= settle_cnt_d;
                avg_sh_q     <= avg_sh_d;
                locked_q     <= locked_d;
                fail_q       <= fail_d;
                done_q       <= done_d;
            end
        end

        assign setpt_v[c]  = setpt_q;
        assign done_v[c]   = done_q;
        assign locked_v[c] = locked_q;
        assign fail_v[c]   = fail_q;
    end

    always_comb begin
        bus.setpt_out_ext = '0;
        bus.lock_done     = '0;
        bus.locked        = '0;
        bus.lock_fail     = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            bus.setpt_out_ext[16*i +: 16] = setpt_v[i];
            bus.lock_done[i]              = done_v[i];
            bus.locked[i]                 = locked_v[i];
            bus.lock_fail[i]              = fail_v[i];
        end
    end
endmodule

// File: tb/tb_dl_multi.sv
// Directed bench for dl_multi: a toy MZI model feeds lane 2 from channel 0's setpoint,
// lane 3 flips between the averaged value and a poison value with lock_sig_active.
module tb_dl_multi;
    localparam int NUM_CH    = 4;
    localparam int NUM_LANES = 16;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;
    logic gap_mode;
    logic sig_level;
    logic sat_watch;
    logic [15:0] sat_max;

    dl_multi_if #(.NUM_CH(NUM_CH), .NUM_LANES(NUM_LANES)) bus ();

    dl_multi #(
        .NUM_CH(NUM_CH), .NUM_LANES(NUM_LANES), .BASE_ADDR(0), .MAX_ITER(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Lane 2 = setpt0/2 (MZI model), lane 3 = -8 while the pulse is present else 200, rest 0.
    always_comb begin
        logic [16*NUM_LANES-1:0] adc;
        adc = '0;
        adc[2*16 +: 16] = {1'b0, bus.setpt_out_ext[15:1]};
        adc[3*16 +: 16] = bus.lock_sig_active ? 16'hFFF8 : 16'd200;
        bus.adc_data_in = adc;
    end

    always @(negedge clk) begin
        bus.lock_sig_active = gap_mode ? ~bus.lock_sig_active : sig_level;
        if (!sat_watch) sat_max = '0;
        else if (bus.setpt_out_ext[63:48] > sat_max) sat_max = bus.setpt_out_ext[63:48];
    end

    task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic gpio_write(input int addr, input logic [15:0] data);
        @(negedge clk);
        bus.gpio_in = {1'b1, 15'(addr), data};
        repeat (4) @(negedge clk);
        bus.gpio_in[31] = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic config_channel(input int ch, input logic [15:0] mx, input logic [15:0] init,
                                  input logic [15:0] expv, input logic [15:0] tol,
                                  input logic [15:0] avg, input logic [15:0] lane,
                                  input logic [15:0] step, input logic [15:0] settle);
        gpio_write(8*ch + 0, mx);
        gpio_write(8*ch + 1, init);
        gpio_write(8*ch + 2, expv);
        gpio_write(8*ch + 3, tol);
        gpio_write(8*ch + 4, avg);
        gpio_write(8*ch + 5, lane);
        gpio_write(8*ch + 6, step);
        gpio_write(8*ch + 7, settle);
    endtask

    task automatic wait_result(input int ch, input int budget);
        int n;
        n = 0;
        while (!(bus.locked[ch] || bus.lock_fail[ch]) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check_output($sformatf("finished_ch%0d", ch), 32'(bus.locked[ch] | bus.lock_fail[ch]), 1);
    endtask

    initial begin
        n_checks      = 0;
        n_fail        = 0;
        gap_mode      = 1'b0;
        sig_level     = 1'b1;
        sat_watch     = 1'b0;
        rst           = 1'b0;
        bus.gpio_in   = '0;
        bus.trig_lock = '0;

        @(negedge clk);
        check_output("rst_setpt", 32'(bus.setpt_out_ext), 0);
        check_output("rst_done", 32'(bus.lock_done), 32'hF);
        check_output("rst_locked", 32'(bus.locked), 0);
        check_output("rst_fail", 32'(bus.lock_fail), 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        // ch1: start loads setpt_init, then abort while still settling.
        config_channel(1, 16'd2000, 16'd1000, 16'd0, 16'd0, 16'd2, 16'd3, 16'd5, 16'd100);
        @(negedge clk);
        bus.trig_lock[1] = 1'b1;
        @(negedge clk);
        check_output("ch1_start_setpt", 32'(bus.setpt_out_ext[31:16]), 1000);
        check_output("ch1_start_done", 32'(bus.lock_done[1]), 0);
        repeat (3) @(negedge clk);
        bus.trig_lock[1] = 1'b0;
        @(negedge clk);
        check_output("ch1_abort_done", 32'(bus.lock_done[1]), 1);
        check_output("ch1_abort_setpt", 32'(bus.setpt_out_ext[31:16]), 1000);

        // ch0 lock; addr 32 must not alias onto ch0 setpt_max.
        config_channel(0, 16'd4000, 16'd960, 16'd500, 16'd10, 16'd2, 16'd2, 16'd5, 16'd0);
        gpio_write(32, 16'd7);
        @(negedge clk);
        bus.trig_lock[0] = 1'b1;
        @(negedge clk);
        check_output("ch0_start_setpt", 32'(bus.setpt_out_ext[15:0]), 960);
        wait_result(0, 400);
        check_output("ch0_locked", 32'(bus.locked[0]), 1);
        check_output("ch0_fail", 32'(bus.lock_fail[0]), 0);
        check_output("ch0_final_setpt", 32'(bus.setpt_out_ext[15:0]), 980);
        check_output("ch0_done", 32'(bus.lock_done[0]), 1);
        bus.trig_lock[0] = 1'b0;

        // ch1 averaging with gaps: only the -8 samples may be accumulated.
        gpio_write(10, 16'hFFF8);
        gpio_write(15, 16'd0);
        gap_mode = 1'b1;
        @(negedge clk);
        bus.trig_lock[1] = 1'b1;
        @(negedge clk);
        wait_result(1, 200);
        check_output("ch1_gap_locked", 32'(bus.locked[1]), 1);
        check_output("ch1_gap_fail", 32'(bus.lock_fail[1]), 0);
        check_output("ch1_gap_setpt", 32'(bus.setpt_out_ext[31:16]), 1000);
        bus.trig_lock[1] = 1'b0;
        gap_mode = 1'b0;

        // ch2 unreachable target: 8 EVALs, 7 steps of 1 from 10.
        config_channel(2, 16'd1000, 16'd10, 16'd30000, 16'd0, 16'd0, 16'd4, 16'd1, 16'd0);
        @(negedge clk);
        bus.trig_lock[2] = 1'b1;
        @(negedge clk);
        wait_result(2, 400);
        check_output("ch2_fail", 32'(bus.lock_fail[2]), 1);
        check_output("ch2_locked", 32'(bus.locked[2]), 0);
        check_output("ch2_setpt", 32'(bus.setpt_out_ext[47:32]), 17);
        bus.trig_lock[2] = 1'b0;
        @(negedge clk);
        check_output("ch2_flag_kept", 32'(bus.lock_fail[2]), 1);

        // ch3 saturation: 98 -> 100 (clamped, dir flips) -> 95 ... -> 70 then FAIL.
        config_channel(3, 16'd100, 16'd98, 16'd30000, 16'd0, 16'd0, 16'd4, 16'd5, 16'd0);
        sat_watch = 1'b1;
        @(negedge clk);
        bus.trig_lock[3] = 1'b1;
        @(negedge clk);
        wait_result(3, 400);
        check_output("ch3_sat_peak", 32'(sat_max), 100);
        check_output("ch3_fail", 32'(bus.lock_fail[3]), 1);
        check_output("ch3_setpt", 32'(bus.setpt_out_ext[63:48]), 70);
        bus.trig_lock[3] = 1'b0;
        sat_watch = 1'b0;

        // Async reset while ch0 sits in ACCUM waiting for a pulse.
        sig_level = 1'b0;
        repeat (2) @(negedge clk);
        bus.trig_lock[0] = 1'b1;
        repeat (5) @(negedge clk);
        check_output("pre_rst_done", 32'(bus.lock_done), 32'hE);
        check_output("pre_rst_locked", 32'(bus.locked), 32'h2);
        #2 rst = 1'b0;
        #1;
        check_output("mid_rst_setpt", 32'(bus.setpt_out_ext), 0);
        check_output("mid_rst_done", 32'(bus.lock_done), 32'hF);
        check_output("mid_rst_locked", 32'(bus.locked), 0);
        check_output("mid_rst_fail", 32'(bus.lock_fail), 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fail);
        $finish;
    end
endmodule
